dp_aux_txn_monitor: RTL
=======================

# dp_aux_txn_monitor

Synthesizable, parametrised AUX transaction protocol monitor on the policy-maker ↔ link-layer boundary. It replaces fixed two-master property checks with per-channel request/reply state machines for `NUM_CH` requesters (ch0 = LPM, ch1 = SPM by default). It also adds reply timeout, defer-retry limit, read-data beat counting and NACK M-byte tracking. Errors are reported as registered pulses with channel and code, plus sticky flags and a saturating count, usable in silicon debug and in the UVM bench.

## Interface
- `NUM_CH`, 2: number of requester channels.
- `LEN_W`, 8: request length field width. LEN encodes bytes−1.
- `MAX_LEN`, 15: largest legal LEN (16 bytes).
- `CMD_MASK`, {16'h0303, 16'h0303}: per-channel 16-bit legal-command mask, indexed by cmd value. Channel i uses bits [16i+15:16i].
- `TIMEOUT_CYC`, 400: cycles allowed from request to reply, and between read data beats.
- `DEFER_MAX`, 7: consecutive DEFERs allowed per channel.
- `ERR_CNT_W`, 8: error counter width.

Ports:
- `clk_AUX`, in, 1: AUX clock. All logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `hpd_detect`, in, 1: sink connected. Low aborts all channels.
- `txn_vld`, in, NUM_CH: request strobe per channel.
- `cmd`, in, 4·NUM_CH: request command. Bit 0 = read, bit 3 = native.
- `len`, in, LEN_W·NUM_CH: request length.
- `ack_vld`, in, NUM_CH: reply ACK strobe.
- `ack`, in, 2·NUM_CH: reply code. 00 = ACK, 01 = NACK, 10 = DEFER, 11 = reserved.
- `data_vld`, in, NUM_CH: reply data beat strobe.
- `busy`, out, NUM_CH: channel has an outstanding transaction.
- `err_valid`, out, 1: one-cycle error pulse.
- `err_ch`, out, $clog2(NUM_CH) (min 1): channel of the reported error.
- `err_code`, out, 4: code of the reported error.
- `err_sticky`, out, 16: bit k is set when code k has ever fired.
- `err_cnt`, out, ERR_CNT_W: saturating count of err_valid pulses.

## Operation
Error codes:
- 1 MULTI_REQ: more than one txn_vld high in a cycle.
- 2 MULTI_REPLY: more than one channel has ack_vld or data_vld high in a cycle.
- 3 BAD_CMD: CMD_MASK bit for cmd is 0.
- 4 LEN_OVF: len > MAX_LEN.
- 5 REQ_BUSY: txn_vld on a channel that is not IDLE.
- 6 UNSOLICITED: ack_vld or data_vld in an unexpected state.
- 7 BAD_ACK: ack = 11.
- 8 TIMEOUT.
- 9 DEFER_LIMIT.
- 10 WR_DATA: data_vld in the cycle after a write ACK.
- 11 NACK_NO_M: NACK_M state exits without data_vld.

Per-channel FSM:
- **IDLE**
  - txn_vld → WAIT_ACK. Latch rd = cmd[0] and len. Clear timer.
  - An illegal cmd or len is still reported (codes 3/4), and the channel is still tracked.
- **WAIT_ACK**: timer increments each cycle. On ack_vld:
  - ACK & rd → RD_DATA, beats = len+1. Clear defer counter.
  - ACK & !rd → IDLE. Clear defer counter. Arm the WR_DATA check for the next cycle.
  - NACK & !rd → NACK_M.
  - NACK & rd → IDLE. Clear defer counter.
  - DEFER → IDLE. Defer counter +1. Reaching DEFER_MAX+1 raises code 9 and clears the counter.
  - 11 → code 7 → IDLE.
  - Timer reaching TIMEOUT_CYC → code 8 → IDLE.
- **RD_DATA**: each data_vld decrements beats, and the timer restarts on each beat. beats reaching 0 → IDLE. Timer reaching TIMEOUT_CYC → code 8 → IDLE.
- **NACK_M**: one cycle only. data_vld → IDLE; otherwise code 11 → IDLE. Defer counter clears.
- data_vld in IDLE or WAIT_ACK, and ack_vld in IDLE, RD_DATA or NACK_M, raise code 6 (except the armed WR_DATA cycle, which raises code 10 instead). The FSM state is unchanged.
- A request in RD_DATA, NACK_M or WAIT_ACK raises code 5 and is ignored.
- hpd_detect low: every channel goes to IDLE, timers and defer counters clear, no error is raised. Requests are ignored while it is low.

Reporting:
- When several errors occur in one cycle, err_code/err_ch report the lowest code, then the lowest channel.
- All simultaneous codes set err_sticky.
- err_cnt increments by 1 per pulse and saturates at all-ones.

## Timing
- Reset values: busy = 0, err_valid = 0, err_ch = 0, err_code = 0, err_sticky = 0, err_cnt = 0. All FSMs are IDLE, all counters are 0.
- Reset mid-transaction aborts silently.
- busy rises the cycle after the accepted txn_vld and falls the cycle after the FSM returns to IDLE.
- err_valid/err_ch/err_code are registered: the pulse appears in cycle N+1 for a violation sampled in cycle N.
- err_sticky and err_cnt update in the same cycle as the pulse.
- Timeout: with the request at cycle 0 and no reply, code 8 is reported in cycle TIMEOUT_CYC+1. A reply in cycle TIMEOUT_CYC−1 is accepted.
- A reply in the same cycle as the request is not accepted and raises code 6.

## Test plan
- ch0 native read, cmd = 1001, len = 3; ACK at +5; 4 data_vld beats → busy high for 9 cycles, no error.
- txn_vld = 2'b11 in the same cycle → err_valid, code 1, ch 0; err_cnt = 1; err_sticky[1] = 1.
- ch0 write, cmd = 1000; no reply for 400 cycles → code 8 at cycle 401; busy low afterwards.
- ch1 I2C write, 8 consecutive DEFERs each followed by a re-request → code 9 on the 8th DEFER.
- ch0 native write NACK with no data_vld next cycle → code 11. Repeat with data_vld → no error.
- hpd_detect drops mid-RD_DATA, then rst asserted with err_cnt = 255 → no error on the drop. rst clears every output; err_cnt saturation is checked beforehand by forcing 300 errors (err_cnt stays 255).

Source files
------------

// File: rtl/dp_aux_txn_monitor_if.sv
// AUX request/reply bus seen by the transaction monitor, plus the monitor's error report.
interface dp_aux_txn_monitor_if #(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned LEN_W     = 8,
    parameter int unsigned ERR_CNT_W = 8
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                    hpd_detect;
    logic [NUM_CH-1:0]       txn_vld;
    logic [4*NUM_CH-1:0]     cmd;
    logic [LEN_W*NUM_CH-1:0] len;
    logic [NUM_CH-1:0]       ack_vld;
    logic [2*NUM_CH-1:0]     ack;
    logic [NUM_CH-1:0]       data_vld;
    logic [NUM_CH-1:0]       busy;
    logic                    err_valid;
    logic [CH_W-1:0]         err_ch;
    logic [3:0]              err_code;
    logic [15:0]             err_sticky;
    logic [ERR_CNT_W-1:0]    err_cnt;

    modport master (
        output hpd_detect, txn_vld, cmd, len, ack_vld, ack, data_vld,
        input  busy, err_valid, err_ch, err_code, err_sticky, err_cnt
    );

    modport slave (
        input  hpd_detect, txn_vld, cmd, len, ack_vld, ack, data_vld,
        output busy, err_valid, err_ch, err_code, err_sticky, err_cnt
    );
endinterface

// File: rtl/dp_aux_txn_monitor.sv
// Per-channel AUX request/reply protocol monitor with registered error pulses,
// sticky code flags and a saturating error counter.
module dp_aux_txn_monitor #(
    parameter int unsigned          NUM_CH      = 2,
    parameter int unsigned          LEN_W       = 8,
    parameter int unsigned          MAX_LEN     = 15,
    parameter logic [16*NUM_CH-1:0] CMD_MASK    = {NUM_CH{16'h0303}},
    parameter int unsigned          TIMEOUT_CYC = 400,
    parameter int unsigned          DEFER_MAX   = 7,
    parameter int unsigned          ERR_CNT_W   = 8
) (
    input logic                 clk_AUX,
    input logic                 rst,
    dp_aux_txn_monitor_if.slave mon
);
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned TMR_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned BEAT_W = LEN_W + 1;
    localparam int unsigned DEF_W  = $clog2(DEFER_MAX + 2);

    localparam int unsigned C_MULTI_REQ   = 1;
    localparam int unsigned C_MULTI_REPLY = 2;
    localparam int unsigned C_BAD_CMD     = 3;
    localparam int unsigned C_LEN_OVF     = 4;
    localparam int unsigned C_REQ_BUSY    = 5;
    localparam int unsigned C_UNSOL       = 6;
    localparam int unsigned C_BAD_ACK     = 7;
    localparam int unsigned C_TIMEOUT     = 8;
    localparam int unsigned C_DEFER_LIM   = 9;
    localparam int unsigned C_WR_DATA     = 10;
    localparam int unsigned C_NACK_NO_M   = 11;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT_ACK, ST_RD_DATA, ST_NACK_M} state_t;

    state_t              r_state     [NUM_CH];
    state_t              w_state_nxt [NUM_CH];
    logic                r_rd        [NUM_CH];
    logic                w_rd_nxt    [NUM_CH];
    logic [LEN_W-1:0]    r_len       [NUM_CH];
    logic [LEN_W-1:0]    w_len_nxt   [NUM_CH];
    logic [TMR_W-1:0]    r_timer     [NUM_CH];
    logic [TMR_W-1:0]    w_timer_nxt [NUM_CH];
    logic [BEAT_W-1:0]   r_beats     [NUM_CH];
    logic [BEAT_W-1:0]   w_beats_nxt [NUM_CH];
    logic [DEF_W-1:0]    r_defer     [NUM_CH];
    logic [DEF_W-1:0]    w_defer_nxt [NUM_CH];
    logic                r_wr_arm    [NUM_CH];
    logic                w_wr_arm_nxt[NUM_CH];
    logic [15:0]         w_err       [NUM_CH];

    logic                w_multi_req;
    logic                w_multi_rep;
    logic [NUM_CH-1:0]   w_reply;
    logic [15:0]         w_err_any;
    logic [3:0]          w_err_code;
    logic [CH_W-1:0]     w_err_ch;

    logic [NUM_CH-1:0]    r_busy;
    logic                 r_err_valid;
    logic [CH_W-1:0]      r_err_ch;
    logic [3:0]           r_err_code;
    logic [15:0]          r_err_sticky;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    assign w_reply     = mon.ack_vld | mon.data_vld;
    assign w_multi_req = ($countones(mon.txn_vld) > 1);
    assign w_multi_rep = ($countones(w_reply) > 1);

    // Next-state and per-channel error detection
    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            w_state_nxt[ch]  = r_state[ch];
            w_rd_nxt[ch]     = r_rd[ch];
            w_len_nxt[ch]    = r_len[ch];
            w_timer_nxt[ch]  = r_timer[ch];
            w_beats_nxt[ch]  = r_beats[ch];
            w_defer_nxt[ch]  = r_defer[ch];
            w_wr_arm_nxt[ch] = 1'b0;
            w_err[ch]        = '0;

            if (!mon.hpd_detect) begin
                w_state_nxt[ch] = ST_IDLE;
                w_timer_nxt[ch] = '0;
                w_defer_nxt[ch] = '0;
            end else begin
                if (w_multi_req && mon.txn_vld[ch])
                    w_err[ch][C_MULTI_REQ] = 1'b1;
                if (w_multi_rep && w_reply[ch])
                    w_err[ch][C_MULTI_REPLY] = 1'b1;
                if (mon.txn_vld[ch] && (r_state[ch] != ST_IDLE))
                    w_err[ch][C_REQ_BUSY] = 1'b1;

                unique case (r_state[ch])
                    ST_IDLE: begin
                        if (mon.data_vld[ch]) begin
                            if (r_wr_arm[ch]) w_err[ch][C_WR_DATA] = 1'b1;
                            else              w_err[ch][C_UNSOL]   = 1'b1;
                        end
                        if (mon.ack_vld[ch])
                            w_err[ch][C_UNSOL] = 1'b1;
                        if (mon.txn_vld[ch]) begin
                            if (!CMD_MASK[16*ch + int'(mon.cmd[4*ch +: 4])])
                                w_err[ch][C_BAD_CMD] = 1'b1;
                            if (mon.len[LEN_W*ch +: LEN_W] > LEN_W'(MAX_LEN))
                                w_err[ch][C_LEN_OVF] = 1'b1;
                            w_state_nxt[ch] = ST_WAIT_ACK;
                            w_rd_nxt[ch]    = mon.cmd[4*ch];
                            w_len_nxt[ch]   = mon.len[LEN_W*ch +: LEN_W];
                            w_timer_nxt[ch] = '0;
                        end
                    end
                    ST_WAIT_ACK: begin
                        if (mon.data_vld[ch])
                            w_err[ch][C_UNSOL] = 1'b1;
                        if (mon.ack_vld[ch]) begin
                            unique case (mon.ack[2*ch +: 2])
                                2'b00: begin
                                    w_defer_nxt[ch] = '0;
                                    if (r_rd[ch]) begin
                                        w_state_nxt[ch] = ST_RD_DATA;
                                        w_beats_nxt[ch] = BEAT_W'(r_len[ch]) + BEAT_W'(1);
                                        w_timer_nxt[ch] = '0;
                                    end else begin
                                        w_state_nxt[ch]  = ST_IDLE;
                                        w_wr_arm_nxt[ch] = 1'b1;
                                    end
                                end
                                2'b01: begin
                                    if (r_rd[ch]) begin
                                        w_state_nxt[ch] = ST_IDLE;
                                        w_defer_nxt[ch] = '0;
                                    end else begin
                                        w_state_nxt[ch] = ST_NACK_M;
                                    end
                                end
                                2'b10: begin
                                    w_state_nxt[ch] = ST_IDLE;
                                    if (r_defer[ch] == DEF_W'(DEFER_MAX)) begin
                                        w_err[ch][C_DEFER_LIM] = 1'b1;
                                        w_defer_nxt[ch] = '0;
                                    end else begin
                                        w_defer_nxt[ch] = r_defer[ch] + DEF_W'(1);
                                    end
                                end
                                2'b11: begin
                                    w_err[ch][C_BAD_ACK] = 1'b1;
                                    w_state_nxt[ch] = ST_IDLE;
                                end
                            endcase
                        end else if (r_timer[ch] == TMR_W'(TIMEOUT_CYC - 1)) begin
                            w_err[ch][C_TIMEOUT] = 1'b1;
                            w_state_nxt[ch] = ST_IDLE;
                        end else begin
                            w_timer_nxt[ch] = r_timer[ch] + TMR_W'(1);
                        end
                    end
                    ST_RD_DATA: begin
                        if (mon.ack_vld[ch])
                            w_err[ch][C_UNSOL] = 1'b1;
                        if (mon.data_vld[ch]) begin
                            w_beats_nxt[ch] = r_beats[ch] - BEAT_W'(1);
                            w_timer_nxt[ch] = '0;
                            if (r_beats[ch] == BEAT_W'(1))
                                w_state_nxt[ch] = ST_IDLE;
                        end else if (r_timer[ch] == TMR_W'(TIMEOUT_CYC - 1)) begin
                            w_err[ch][C_TIMEOUT] = 1'b1;
                            w_state_nxt[ch] = ST_IDLE;
                        end else begin
                            w_timer_nxt[ch] = r_timer[ch] + TMR_W'(1);
                        end
                    end
                    ST_NACK_M: begin
                        if (mon.ack_vld[ch])
                            w_err[ch][C_UNSOL] = 1'b1;
                        if (!mon.data_vld[ch])
                            w_err[ch][C_NACK_NO_M] = 1'b1;
                        w_state_nxt[ch] = ST_IDLE;
                        w_defer_nxt[ch] = '0;
                    end
                endcase
            end
        end
    end

    // Lowest code wins, then lowest channel; iterating downwards leaves the winner last
    always_comb begin
        w_err_any  = '0;
        w_err_code = '0;
        w_err_ch   = '0;
        for (int ch = 0; ch < NUM_CH; ch++)
            w_err_any = w_err_any | w_err[ch];
        for (int c = 15; c >= 1; c--) begin
            for (int ch = NUM_CH - 1; ch >= 0; ch--) begin
                if (w_err[ch][c]) begin
                    w_err_code = 4'(c);
                    w_err_ch   = CH_W'(ch);
                end
            end
        end
    end

    always_ff @(posedge clk_AUX) begin
        if (rst) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                r_state[ch]  <= ST_IDLE;
                r_rd[ch]     <= 1'b0;
                r_len[ch]    <= '0;
                r_timer[ch]  <= '0;
                r_beats[ch]  <= '0;
                r_defer[ch]  <= '0;
                r_wr_arm[ch] <= 1'b0;
            end
            r_busy       <= '0;
            r_err_valid  <= 1'b0;
            r_err_ch     <= '0;
            r_err_code   <= '0;
            r_err_sticky <= '0;
            r_err_cnt    <= '0;
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                r_state[ch]  <= w_state_nxt[ch];
                r_rd[ch]     <= w_rd_nxt[ch];
                r_len[ch]    <= w_len_nxt[ch];
                r_timer[ch]  <= w_timer_nxt[ch];
                r_beats[ch]  <= w_beats_nxt[ch];
                r_defer[ch]  <= w_defer_nxt[ch];
                r_wr_arm[ch] <= w_wr_arm_nxt[ch];
                r_busy[ch]   <= (w_state_nxt[ch] != ST_IDLE);
            end
            r_err_valid  <= |w_err_any;
            r_err_ch     <= w_err_ch;
            r_err_code   <= w_err_code;
            r_err_sticky <= r_err_sticky | w_err_any;
            if ((|w_err_any) && (r_err_cnt != '1))
                r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
        end
    end

    assign mon.busy       = r_busy;
    assign mon.err_valid  = r_err_valid;
    assign mon.err_ch     = r_err_ch;
    assign mon.err_code   = r_err_code;
    assign mon.err_sticky = r_err_sticky;
    assign mon.err_cnt    = r_err_cnt;
endmodule
